// File: rtl/trdll_update_ctrl.sv
// trdll_update_ctrl
// Sequencer for the TRDLLB delay-locked loop. It resets the DLL, qualifies
// LOCK with bounded retries, and periodically moves a fresh DCNTL code
// (ALUHOLD setup, UDDCNTL pulse, release). Each transfer first obtains a
// quiet window from the datapath through UPD_REQ/UPD_ACK.
//
// Ports (all logic on posedge CLKI, RSTN synchronous active-low):
//   CLKI, RSTN                 clock / reset
//   DLL_LOCK                   LOCK from DLL (already synchronised)
//   UPD_ACK                    datapath grants quiet window
//   UPD_NOW                    one-cycle request for an immediate update
//   DLL_RSTN, ALUHOLD, UDDCNTL DLL control pins
//   UPD_REQ                    quiet-window request
//   READY                      DLL locked and code valid
//   LOCK_LOST, FAIL            sticky status
//   RETRY_CNT[3:0]             failed lock attempts since last qualification
//   STATE[2:0]                 current state (debug)
//   UPD_MISS                   sticky, only with TRDLL_ACK_TIMEOUT_EN
//
// Optional feature macro: TRDLL_ACK_TIMEOUT_EN -- bounds the wait for UPD_ACK
// to ACK_TIMEOUT cycles and adds the UPD_MISS output.
module trdll_update_ctrl #(
  parameter int unsigned RST_CYC         = 16,
  parameter int unsigned LOCK_STABLE_CYC = 64,
  parameter int unsigned LOCK_TIMEOUT    = 4096,
  parameter int unsigned UPD_INTERVAL    = 1024,
  parameter int unsigned HOLD_SETUP      = 2,
  parameter int unsigned UPD_PULSE       = 4,
  parameter int unsigned MAX_RETRY       = 7,
  parameter int unsigned ACK_TIMEOUT     = 256
) (
  input  logic       CLKI,
  input  logic       RSTN,
  input  logic       DLL_LOCK,
  input  logic       UPD_ACK,
  input  logic       UPD_NOW,
  output logic       DLL_RSTN,
  output logic       ALUHOLD,
  output logic       UDDCNTL,
  output logic       UPD_REQ,
  output logic       READY,
  output logic       LOCK_LOST,
  output logic       FAIL,
  output logic [3:0] RETRY_CNT,
`ifdef TRDLL_ACK_TIMEOUT_EN
  output logic       UPD_MISS,
`endif
  output logic [2:0] STATE
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CMAX = max2(max2(max2(RST_CYC, LOCK_STABLE_CYC),
                                           max2(LOCK_TIMEOUT, UPD_INTERVAL)),
                                      max2(max2(HOLD_SETUP, UPD_PULSE), ACK_TIMEOUT));
  localparam int CW = $clog2(CMAX + 1);

  // Terminal counts: the shared counter restarts at 0 on every state change,
  // so a state lasting N cycles leaves when the counter shows N-1.
  localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] INT_LAST   = CW'(UPD_INTERVAL - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_SETUP - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(UPD_PULSE - 1);
`ifdef TRDLL_ACK_TIMEOUT_EN
  localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
`endif
  localparam logic [CW-1:0] STAB_N     = CW'(LOCK_STABLE_CYC);
  localparam logic [3:0]    MAXR       = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST = 3'd0, S_WAIT = 3'd1, S_TRACK = 3'd2, S_REQ = 3'd3,
    S_HOLD = 3'd4, S_UPD = 3'd5, S_REL = 3'd6, S_FAIL = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] stab_q, stab_d, stab_inc;
  logic [3:0]    retry_q, retry_d, retry_inc;
  logic          pend_q, pend_d;
  logic          lost_q, lost_d;
  logic          fail_q, fail_d;
  logic          ready_q, ready_d;
  logic          dll_rstn_q, aluhold_q, uddcntl_q, upd_req_q;
  logic          lock_to;
`ifdef TRDLL_ACK_TIMEOUT_EN
  logic          miss_q, miss_d;
`endif

  // All counters saturate rather than wrap.
  assign cnt_inc   = (&cnt_q)   ? cnt_q   : cnt_q   + 1'b1;
  assign stab_inc  = (&stab_q)  ? stab_q  : stab_q  + 1'b1;
  assign retry_inc = (&retry_q) ? retry_q : retry_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    stab_d  = '0;
    retry_d = retry_q;
    pend_d  = pend_q | (UPD_NOW & (state_q != S_TRACK));
    lost_d  = lost_q;
    fail_d  = fail_q;
    ready_d = 1'b0;
    lock_to = 1'b0;
`ifdef TRDLL_ACK_TIMEOUT_EN
    miss_d  = miss_q;
`endif
    case (state_q)
      S_RST:   if (cnt_q == RST_LAST) state_d = S_WAIT;
      S_WAIT: begin
        if (DLL_LOCK) stab_d = stab_inc;
        // Qualification beats a timeout on the same cycle.
        if (DLL_LOCK && stab_inc == STAB_N) state_d = S_REQ;
        else if (cnt_q == WAIT_LAST)        lock_to = 1'b1;
      end
      S_TRACK: if (cnt_q == INT_LAST || UPD_NOW || pend_q) state_d = S_REQ;
      S_REQ: begin
        if (UPD_ACK) state_d = S_HOLD;
`ifdef TRDLL_ACK_TIMEOUT_EN
        else if (cnt_q == ACK_LAST) begin
          // Periodic update is skipped; a missed initial update counts as
          // a failed lock attempt.
          if (ready_q) begin
            state_d = S_TRACK;
            miss_d  = 1'b1;
          end else begin
            lock_to = 1'b1;
          end
        end
`endif
      end
      S_HOLD:  if (cnt_q == HOLD_LAST)  state_d = S_UPD;
      S_UPD:   if (cnt_q == PULSE_LAST) state_d = S_REL;
      S_REL:   state_d = S_TRACK;
      default: state_d = S_FAIL;  // only RSTN leaves S_FAIL
    endcase

    if (lock_to) begin
      retry_d = retry_inc;
      state_d = (retry_inc == MAXR) ? S_FAIL : S_RST;
    end

    // Losing lock once qualified aborts whatever update is in flight.
    if (!DLL_LOCK && (state_q inside {S_TRACK, S_REQ, S_HOLD, S_UPD, S_REL})) begin
      state_d = S_RST;
      lost_d  = 1'b1;
    end

    if (state_d != state_q)                      cnt_d   = '0;
    if (state_d == S_REQ && state_q != S_REQ)    pend_d  = 1'b0;
    if (state_d == S_TRACK)                      retry_d = '0;
    if (state_d == S_FAIL)                       fail_d  = 1'b1;

    // READY rises on the first return to tracking and is held across
    // later updates.
    case (state_d)
      S_TRACK:                      ready_d = 1'b1;
      S_REQ, S_HOLD, S_UPD, S_REL:  ready_d = ready_q;
      default:                      ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLKI) begin
    if (!RSTN) begin
      state_q    <= S_RST;
      cnt_q      <= '0;
      stab_q     <= '0;
      retry_q    <= '0;
      pend_q     <= 1'b0;
      lost_q     <= 1'b0;
      fail_q     <= 1'b0;
      ready_q    <= 1'b0;
      dll_rstn_q <= 1'b0;
      aluhold_q  <= 1'b0;
      uddcntl_q  <= 1'b0;
      upd_req_q  <= 1'b0;
`ifdef TRDLL_ACK_TIMEOUT_EN
      miss_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stab_q     <= stab_d;
      retry_q    <= retry_d;
      pend_q     <= pend_d;
      lost_q     <= lost_d;
      fail_q     <= fail_d;
      ready_q    <= ready_d;
      dll_rstn_q <= !(state_d == S_RST || state_d == S_FAIL);
      aluhold_q  <= state_d inside {S_HOLD, S_UPD, S_REL};
      uddcntl_q  <= (state_d == S_UPD);
      upd_req_q  <= state_d inside {S_REQ, S_HOLD, S_UPD, S_REL};
`ifdef TRDLL_ACK_TIMEOUT_EN
      miss_q     <= miss_d;
`endif
    end
  end

  assign DLL_RSTN  = dll_rstn_q;
  assign ALUHOLD   = aluhold_q;
  assign UDDCNTL   = uddcntl_q;
  assign UPD_REQ   = upd_req_q;
  assign READY     = ready_q;
  assign LOCK_LOST = lost_q;
  assign FAIL      = fail_q;
  assign RETRY_CNT = retry_q;
  assign STATE     = state_q;
`ifdef TRDLL_ACK_TIMEOUT_EN
  assign UPD_MISS  = miss_q;
`endif

endmodule

// File: tb/tb_trdll_update_ctrl.sv
// Directed bench for trdll_update_ctrl. Outputs are sampled 1 time unit after
// each rising edge; inputs are changed at the same point.
module tb_trdll_update_ctrl;

  logic       CLKI = 1'b0;
  logic       RSTN, DLL_LOCK, UPD_ACK, UPD_NOW;
  logic       DLL_RSTN, ALUHOLD, UDDCNTL, UPD_REQ, READY, LOCK_LOST, FAIL;
  logic [3:0] RETRY_CNT;
  logic [2:0] STATE;
`ifdef TRDLL_ACK_TIMEOUT_EN
  logic       UPD_MISS;
`endif

  int npass = 0;
  int nchk  = 0;
  int nfail = 0;

  always #5 CLKI = ~CLKI;

  trdll_update_ctrl #(
    .RST_CYC(4), .LOCK_STABLE_CYC(8), .LOCK_TIMEOUT(32), .UPD_INTERVAL(16),
    .HOLD_SETUP(2), .UPD_PULSE(4), .MAX_RETRY(3), .ACK_TIMEOUT(8)
  ) dut (
    .CLKI(CLKI), .RSTN(RSTN), .DLL_LOCK(DLL_LOCK), .UPD_ACK(UPD_ACK),
    .UPD_NOW(UPD_NOW), .DLL_RSTN(DLL_RSTN), .ALUHOLD(ALUHOLD),
    .UDDCNTL(UDDCNTL), .UPD_REQ(UPD_REQ), .READY(READY),
    .LOCK_LOST(LOCK_LOST), .FAIL(FAIL), .RETRY_CNT(RETRY_CNT),
`ifdef TRDLL_ACK_TIMEOUT_EN
    .UPD_MISS(UPD_MISS),
`endif
    .STATE(STATE)
  );

  task automatic tick();
    @(posedge CLKI);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {STATE, DLL_RSTN, ALUHOLD, UDDCNTL, UPD_REQ, READY}
  function automatic logic [7:0] pk();
    return {STATE, DLL_RSTN, ALUHOLD, UDDCNTL, UPD_REQ, READY};
  endfunction

  // Bring-up, one entry per edge after reset release (RST 4, WAIT 8,
  // REQ 1 with ACK tied high, HOLD 2, UPD 4, REL 1, then TRACK).
  logic [7:0] exp_bu [20] = '{
    8'b000_00000, 8'b000_00000, 8'b000_00000,
    8'b001_10000, 8'b001_10000, 8'b001_10000, 8'b001_10000,
    8'b001_10000, 8'b001_10000, 8'b001_10000, 8'b001_10000,
    8'b011_10010,
    8'b100_11010, 8'b100_11010,
    8'b101_11110, 8'b101_11110, 8'b101_11110, 8'b101_11110,
    8'b110_11010,
    8'b010_10001
  };

  initial begin
    int n;
    int udd;
    RSTN = 1'b0; DLL_LOCK = 1'b1; UPD_ACK = 1'b1; UPD_NOW = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_outs", pk(), 8'h00);
    chk("rst_lost", LOCK_LOST, 0);
    chk("rst_fail", FAIL, 0);
    chk("rst_retry", RETRY_CNT, 0);
    RSTN = 1'b1;

    // Bring-up cycle by cycle
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("bringup_%0d", i), pk(), exp_bu[i]);
    end

    // Periodic update with ACK held off
    UPD_ACK = 1'b0;
    n = 0;
    while (STATE == 3'd2 && n < 40) begin tick(); n++; end
    chk("track_len1", n, 16);
    chk("req_rise", {STATE, UPD_REQ}, {3'd3, 1'b1});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("ack_wait_%0d", i), {STATE, ALUHOLD}, {3'd3, 1'b0});
    end
    UPD_ACK = 1'b1;
    n = 0; udd = 0;
    do begin tick(); n++; if (UDDCNTL) udd++; end while (UPD_REQ && n < 40);
    chk("req_len", 5 + n - 1, 12);
    chk("udd_len", udd, 4);
    chk("back_track", pk(), 8'b010_10001);
    n = 0;
    while (STATE == 3'd2 && n < 40) begin tick(); n++; end
    chk("track_len2", n, 16);

    // Two UPD_NOW pulses during an update collapse into one extra update
    tick();
    chk("in_hold", STATE, 3'd4);
    UPD_NOW = 1'b1; tick(); UPD_NOW = 1'b0;
    tick();
    chk("in_upd", STATE, 3'd5);
    UPD_NOW = 1'b1; tick(); UPD_NOW = 1'b0;
    n = 0;
    while (STATE != 3'd2 && n < 20) begin tick(); n++; end
    chk("now_track", STATE, 3'd2);
    tick();
    chk("now_retrig", STATE, 3'd3);
    n = 0;
    while (STATE != 3'd2 && n < 20) begin tick(); n++; end
    n = 0;
    while (STATE == 3'd2 && n < 40) begin tick(); n++; end
    chk("now_coalesce", n, 16);

    // Lock loss during the second UDDCNTL cycle
    n = 0;
    while (!UDDCNTL && n < 20) begin tick(); n++; end
    chk("udd_first", UDDCNTL, 1);
    tick();
    chk("udd_second", UDDCNTL, 1);
    DLL_LOCK = 1'b0;
    tick();
    chk("abort_outs", pk(), 8'h00);
    chk("abort_lost", LOCK_LOST, 1);
    chk("abort_retry", RETRY_CNT, 0);

    // Retry exhaustion with DLL_LOCK stuck low
    n = 0;
    while (RETRY_CNT != 4'd1 && n < 100) begin tick(); n++; end
    chk("retry1_time", n, 36);
    chk("retry1_state", {STATE, DLL_RSTN}, {3'd0, 1'b0});
    for (int i = 0; i < 4; i++) tick();
    chk("retry_wait_rstn", {STATE, DLL_RSTN}, {3'd1, 1'b1});
    n = 0;
    while (RETRY_CNT != 4'd2 && n < 100) begin tick(); n++; end
    chk("retry2_time", n, 32);
    n = 0;
    while (!FAIL && n < 100) begin tick(); n++; end
    chk("fail_time", n, 36);
    chk("fail_outs", {STATE, DLL_RSTN, READY, RETRY_CNT}, {3'd7, 1'b0, 1'b0, 4'd3});
    for (int i = 0; i < 10; i++) tick();
    chk("fail_sticky", {STATE, DLL_RSTN, FAIL, LOCK_LOST}, {3'd7, 1'b0, 1'b1, 1'b1});

    // RSTN pulse clears everything
    RSTN = 1'b0;
    tick();
    chk("rst2_outs", pk(), 8'h00);
    chk("rst2_sticky", {FAIL, LOCK_LOST, RETRY_CNT}, 6'd0);
    DLL_LOCK = 1'b1; RSTN = 1'b1;

    // A one-cycle LOCK dropout in S_WAIT restarts qualification
    for (int i = 0; i < 4; i++) tick();
    chk("wait2", STATE, 3'd1);
    for (int i = 0; i < 5; i++) tick();
    DLL_LOCK = 1'b0; tick(); DLL_LOCK = 1'b1;
    UPD_ACK = 1'b0;
    n = 0;
    while (STATE != 3'd3 && n < 40) begin tick(); n++; end
    chk("stable_restart", n, 8);

`ifdef TRDLL_ACK_TIMEOUT_EN
    // Initial update never acknowledged: counts as a failed attempt
    for (int i = 0; i < 7; i++) tick();
    chk("ackto_still_req", STATE, 3'd3);
    tick();
    chk("ackto_init", {STATE, RETRY_CNT, UPD_REQ}, {3'd0, 4'd1, 1'b0});
    UPD_ACK = 1'b1;
    n = 0;
    while (!READY && n < 80) begin tick(); n++; end
    chk("ackto_ready", READY, 1);
    UPD_ACK = 1'b0;
    n = 0;
    while (STATE != 3'd3 && n < 40) begin tick(); n++; end
    udd = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (UDDCNTL) udd++; end
    chk("ackto_periodic", {STATE, UPD_MISS, READY, UPD_REQ}, {3'd2, 1'b1, 1'b1, 1'b0});
    chk("ackto_no_udd", udd, 0);
`else
    // Without the timeout, S_REQ waits indefinitely
    for (int i = 0; i < 20; i++) tick();
    chk("req_forever", {STATE, ALUHOLD, UPD_REQ}, {3'd3, 1'b0, 1'b1});
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
